// File: rtl/sphere_fetch_pkg.sv
// rtl/sphere_fetch_pkg.sv - shared constants and state type for the sphere pair fetcher
package sphere_fetch_pkg;

  localparam int PAIR_WORDS = 8;

  // Word slots inside one pair record
  localparam int P1X = 0;
  localparam int P1Y = 1;
  localparam int P1Z = 2;
  localparam int R1  = 3;
  localparam int P2X = 4;
  localparam int P2Y = 5;
  localparam int P2Z = 6;
  localparam int R2  = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - show-ahead synchronous FIFO holding captured pair records
module pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sphere_pair_fetch.sv
// rtl/sphere_pair_fetch.sv - RAM read sequencer and pair buffer for the sphere collide pipeline
// Optional: define SPHERE_FETCH_STALL_CNT_EN to add the stall_cycles counter output.
module sphere_pair_fetch
  import sphere_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH-1:0]            num_pairs,
  output logic                             busy,
  output logic                             done,
  output logic                             mem_cs,
  output logic                             mem_oe,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rdata0,
  input  logic [DATA_WIDTH-1:0]            mem_rdata1,
  input  logic [DATA_WIDTH-1:0]            mem_rdata2,
  input  logic [DATA_WIDTH-1:0]            mem_rdata3,
  input  logic [DATA_WIDTH-1:0]            mem_rdata4,
  input  logic [DATA_WIDTH-1:0]            mem_rdata5,
  input  logic [DATA_WIDTH-1:0]            mem_rdata6,
  input  logic [DATA_WIDTH-1:0]            mem_rdata7,
  output logic                             pair_valid,
  input  logic                             pair_ready,
  output logic [PAIR_WORDS*DATA_WIDTH-1:0] pair_data,
  output logic [ADDR_WIDTH-1:0]            pair_idx
`ifdef SPHERE_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int REC_W = PAIR_WORDS * DATA_WIDTH;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(PAIR_WORDS);

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] num_reg;
  logic [ADDR_WIDTH-1:0] issued;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] v1_idx;
  logic [ADDR_WIDTH-1:0] v2_idx;
  logic                  v2;
  logic                  issue;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic [CW:0]           credit_use;
  logic [DATA_WIDTH-1:0] words [PAIR_WORDS];
  logic [REC_W-1:0]      rec;
  logic [REC_W+ADDR_WIDTH-1:0] fifo_out;

  assign words[P1X] = mem_rdata0;
  assign words[P1Y] = mem_rdata1;
  assign words[P1Z] = mem_rdata2;
  assign words[R1]  = mem_rdata3;
  assign words[P2X] = mem_rdata4;
  assign words[P2Y] = mem_rdata5;
  assign words[P2Z] = mem_rdata6;
  assign words[R2]  = mem_rdata7;

  always_comb begin
    rec = '0;
    for (int k = 0; k < PAIR_WORDS; k++) begin
      rec[k*DATA_WIDTH +: DATA_WIDTH] = words[k];
    end
  end

  assign mem_we     = 1'b0;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign pair_valid = !empty;
  assign pop        = pair_valid && pair_ready;
  assign pair_data  = pair_valid ? fifo_out[REC_W-1:0] : '0;
  assign pair_idx   = pair_valid ? fifo_out[REC_W +: ADDR_WIDTH] : '0;

  // Slots already spoken for: post-pop occupancy plus reads still in the RAM pipe
  assign credit_use = {1'b0, count} - (CW + 1)'(pop) + (CW + 1)'(mem_oe) + (CW + 1)'(v2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_pairs != '0) begin
            state_nxt = RUN;
            issue     = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (issued == num_reg) begin
          state_nxt = DRAIN;
        end else if (credit_use < DEPTH_C) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (!mem_oe && !v2 && credit_use == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // mem_oe doubles as the first stage of the read pipe; v2 marks RAM data present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= '0;
      next_addr <= '0;
      issued    <= '0;
      num_reg   <= '0;
      v1_idx    <= '0;
      v2_idx    <= '0;
      v2        <= 1'b0;
    end else begin
      mem_cs <= issue;
      mem_oe <= issue;
      v2     <= mem_oe;
      v2_idx <= v1_idx;
      if (state == IDLE && start) begin
        num_reg <= num_pairs;
      end
      if (issue) begin
        if (state == IDLE) begin
          mem_addr  <= base_addr;
          next_addr <= base_addr + STRIDE;
          issued    <= ADDR_WIDTH'(1);
          v1_idx    <= '0;
        end else begin
          mem_addr  <= next_addr;
          next_addr <= next_addr + STRIDE;
          issued    <= issued + ADDR_WIDTH'(1);
          v1_idx    <= issued;
        end
      end
    end
  end

  pair_fifo #(
    .WIDTH(REC_W + ADDR_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (v2),
    .push_data({v2_idx, rec}),
    .pop      (pop),
    .pop_data (fifo_out),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  overflow_check: assert property (@(posedge clk) disable iff (rst) !(v2 && full && !pop));

`ifdef SPHERE_FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (pair_valid && !pair_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sphere_pair_fetch.sv
// tb/tb_sphere_pair_fetch.sv - scoreboard bench for sphere_pair_fetch against a RAM and record model
module tb_sphere_pair_fetch;

  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0]   idx;
    logic [8*DW-1:0] data;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   num_pairs;
  logic            busy;
  logic            done;
  logic            mem_cs;
  logic            mem_oe;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   rd [8];
  logic            pair_valid;
  logic            pair_ready;
  logic [8*DW-1:0] pair_data;
  logic [AW-1:0]   pair_idx;
`ifdef SPHERE_FETCH_STALL_CNT_EN
  logic [31:0]     stall_cycles;
`endif

  int total = 0;
  int bad = 0;
  rec_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  rec_t mon_e;
  time t_e0 = 0;
  int oe_count, oe_first, oe_last, first_valid, last_hs, done_cyc, done_count;
  logic hold_v;
  logic [8*DW-1:0] hold_data;
  logic [AW-1:0] hold_idx;
  int rmode = 0;

  sphere_pair_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_pairs  (num_pairs),
    .busy       (busy),
    .done       (done),
    .mem_cs     (mem_cs),
    .mem_oe     (mem_oe),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_rdata0 (rd[0]),
    .mem_rdata1 (rd[1]),
    .mem_rdata2 (rd[2]),
    .mem_rdata3 (rd[3]),
    .mem_rdata4 (rd[4]),
    .mem_rdata5 (rd[5]),
    .mem_rdata6 (rd[6]),
    .mem_rdata7 (rd[7]),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .pair_data  (pair_data),
    .pair_idx   (pair_idx)
`ifdef SPHERE_FETCH_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return a * 32'h9E3779B1 + 32'h01357BDF;
  endfunction

  function automatic int cyc_now();
    return int'(($time - t_e0 + 5) / 10);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Synchronous RAM: data appears the cycle after cs/oe; poison otherwise
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      rd[k] <= (mem_cs && mem_oe) ? ram_word(mem_addr + AW'(k)) : (32'hDEADBEEF ^ 32'(k));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) pair_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (mem_oe) begin
        oe_count++;
        if (oe_first < 0) oe_first = cyc_now();
        oe_last = cyc_now();
        check("read_cs", 256'(mem_cs), 256'(1));
        check("read_we", 256'(mem_we), 256'(0));
        check("read_expected", 256'(addr_q.size() != 0), 256'(1));
        if (addr_q.size() != 0) check("read_addr", 256'(mem_addr), 256'(addr_q.pop_front()));
      end
      if (hold_v && pair_valid) begin
        check("hold_data", pair_data, hold_data);
        check("hold_idx", 256'(pair_idx), 256'(hold_idx));
      end
      hold_v    = pair_valid && !pair_ready;
      hold_data = pair_data;
      hold_idx  = pair_idx;
      if (pair_valid && first_valid < 0) first_valid = cyc_now();
      if (pair_valid && pair_ready) begin
        last_hs = cyc_now();
        check("pair_expected", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("pair_idx", 256'(pair_idx), 256'(mon_e.idx));
          check("pair_data", pair_data, mon_e.data);
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc_now();
        check("busy_at_done", 256'(busy), 256'(0));
        check("left_at_done", 256'(exp_q.size()), 256'(0));
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
    rec_t r;
    oe_count = 0; oe_first = -1; oe_last = -1; first_valid = -1;
    last_hs = -1; done_cyc = -1; done_count = 0;
    for (int i = 0; i < int'(n); i++) begin
      addr_q.push_back(b + AW'(8 * i));
      r.idx = AW'(i);
      for (int k = 0; k < 8; k++) r.data[k*DW +: DW] = ram_word(b + AW'(8 * i + k));
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    base_addr = b;
    num_pairs = n;
    start = 1'b1;
    @(posedge clk);
    t_e0 = $time;
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (done_count == 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check({name, "_done_seen"}, 256'(done_count != 0), 256'(1));
    @(posedge clk);
    #1;
    check({name, "_done_once"}, 256'(done_count), 256'(1));
    check({name, "_pairs_left"}, 256'(exp_q.size()), 256'(0));
    check({name, "_reads_left"}, 256'(addr_q.size()), 256'(0));
    check({name, "_busy_after"}, 256'(busy), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [AW-1:0] b;
    logic [AW-1:0] n;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_pairs = '0; pair_ready = 1'b0;
    hold_v = 1'b0;
    oe_count = 0; oe_first = -1; oe_last = -1; first_valid = -1;
    last_hs = -1; done_cyc = -1; done_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_cs", 256'(mem_cs), 256'(0));
    check("rst_oe", 256'(mem_oe), 256'(0));
    check("rst_we", 256'(mem_we), 256'(0));
    check("rst_addr", 256'(mem_addr), 256'(0));
    check("rst_valid", 256'(pair_valid), 256'(0));
    check("rst_idx", 256'(pair_idx), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three pairs, consumer always ready: exact latency and throughput
    pair_ready = 1'b1;
    start_job(32'h0, 32'd3);
    wait_done("basic");
    check("basic_oe_first", 256'(oe_first), 256'(1));
    check("basic_oe_last", 256'(oe_last), 256'(3));
    check("basic_oe_count", 256'(oe_count), 256'(3));
    check("basic_first_valid", 256'(first_valid), 256'(3));
    check("basic_last_hs", 256'(last_hs), 256'(5));
    check("basic_done_cyc", 256'(done_cyc), 256'(6));

    // Empty run: no RAM access, done the next cycle
    start_job(32'h1000, 32'd0);
    wait_done("empty");
    check("empty_oe_count", 256'(oe_count), 256'(0));
    check("empty_done_cyc", 256'(done_cyc), 256'(1));

    // Back-pressure: credit limit stops issue at the FIFO depth
    pair_ready = 1'b0;
    start_job(32'h200, 32'd10);
    repeat (20) @(posedge clk);
    #1;
    check("stall_reads", 256'(oe_count), 256'(4));
    check("stall_valid", 256'(pair_valid), 256'(1));
    pair_ready = 1'b1;
    wait_done("stall");
    check("stall_total_reads", 256'(oe_count), 256'(10));

    // Address wrap at the top of the space
    start_job(32'hFFFFFFF8, 32'd2);
    wait_done("wrap");

    // Reset mid-run aborts everything without a done
    start_job(32'h300, 32'd6);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_done", 256'(done), 256'(0));
    check("abort_cs", 256'(mem_cs), 256'(0));
    check("abort_oe", 256'(mem_oe), 256'(0));
    check("abort_addr", 256'(mem_addr), 256'(0));
    check("abort_valid", 256'(pair_valid), 256'(0));
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 256'(done_count), 256'(0));
    check("abort_no_read", 256'(mem_oe), 256'(0));
    start_job(32'h300, 32'd6);
    wait_done("rerun");

    // Random bases, lengths and consumer stalls
    for (int t = 0; t < 8; t++) begin
      b = $urandom;
      n = AW'($urandom_range(1, 12));
      rmode = 1;
      start_job(b, n);
      wait_done("random");
      rmode = 0;
      pair_ready = 1'b1;
    end

`ifdef SPHERE_FETCH_STALL_CNT_EN
    pair_ready = 1'b0;
    start_job(32'h40, 32'd1);
    c = 0;
    while (!pair_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("cnt_valid_seen", 256'(pair_valid), 256'(1));
    repeat (5) @(posedge clk);
    #1;
    pair_ready = 1'b1;
    wait_done("cnt");
    check("stall_cycles", 256'(stall_cycles), 256'(5));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sphere_pair_fetch.md
# sphere_pair_fetch

Read sequencer and buffer between the sphere-data RAM and the 5-stage dCollideSpheres pipeline. On `start` it walks `num_pairs` consecutive 8-word sphere-pair records, drives the RAM's chip select, output enable and read address, and captures each 8-word read burst. Captured records go into a small FIFO and are presented to the collide pipeline on a valid/ready handshake, sustaining one pair per clock when the consumer never stalls.

## Interface
- `DATA_WIDTH`, 32: width of one RAM word.
- `ADDR_WIDTH`, 32: RAM word-address width.
- `FIFO_DEPTH`, 4: pair records buffered; power of two, at least 4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a run; ignored while `busy`.
- `base_addr`  in  ADDR_WIDTH: word address of pair 0; sampled at `start`.
- `num_pairs`  in  ADDR_WIDTH: pair count; sampled at `start`.
- `busy`  out  1: high from the accepted `start` until `done`.
- `done`  out  1: one-cycle pulse after the last pair handshake.
- `mem_cs`  out  1: RAM chip select.
- `mem_oe`  out  1: RAM output enable.
- `mem_we`  out  1: RAM write enable; constant 0.
- `mem_addr`  out  ADDR_WIDTH: RAM read address (`addressout`).
- `mem_rdata0`..`mem_rdata7`  in  DATA_WIDTH each: RAM read words.
- `pair_valid`  out  1: `pair_data` holds a record.
- `pair_ready`  in  1: consumer accepts the record.
- `pair_data`  out  8*DATA_WIDTH: record; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]. Word order: p1x, p1y, p1z, r1, p2x, p2y, p2z, r2.
- `pair_idx`  out  ADDR_WIDTH: index of the record presented on `pair_data`.

## Operation
- Reset values: all outputs 0; `mem_addr` 0; FIFO empty; state IDLE.
- States:
  - IDLE: waits for `start`.
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for the FIFO to empty.
  - DONE: one cycle; pulses `done` and returns to IDLE.
- Transitions:
  - IDLE→RUN on `start` with `num_pairs`≠0.
  - IDLE→DONE on `start` with `num_pairs`=0; no RAM access occurs.
  - RUN→DRAIN when issued count = `num_pairs`.
  - DRAIN→DONE when in-flight reads = 0, FIFO empty, and the final handshake has occurred.
- Issue rule in RUN: issue a read when occupancy + in_flight < FIFO_DEPTH. Occupancy is the post-pop value for this cycle (a same-cycle pop frees a slot).
- Read `i` address: `mem_addr` = `base_addr` + 8·i, computed modulo 2^ADDR_WIDTH. Address wrap is silent.
- `mem_cs`/`mem_oe` are registered, high only in the cycle an address is driven, so a burst issue holds them high continuously.
- Capture: the 8 `mem_rdata` words are sampled one cycle after the issue cycle and pushed together with their index. The RAM output is undriven (z) outside reads and must never be sampled then.
- FIFO:
  - A push and a pop in the same cycle are both honoured.
  - Overflow cannot occur given the credit rule; an assertion checks this.
- `pair_data` and `pair_idx` are stable while `pair_valid && !pair_ready`.
- `rst` mid-run: aborts the run immediately, flushes the FIFO, discards in-flight data, and produces no `done`.

## Timing
- `start` sampled at edge E0 → `mem_addr` = base and `mem_oe` high in cycle 1 → RAM registers at E1 → block captures at E2 → `pair_valid` high in cycle 3.
- Start-to-first-valid latency is 3 cycles.
- Throughput is 1 pair/clk with `pair_ready` held high.
- `done` is asserted the cycle after the final handshake.
- `busy` falls in the same cycle `done` pulses.
- A new `start` is accepted the cycle after `done`.

## Configuration
- `SPHERE_FETCH_STALL_CNT_EN`:
  - Defined: adds output `stall_cycles` (32 bits). It counts cycles with `pair_valid && !pair_ready`, clears at an accepted `start` and on `rst`, and saturates at 2^32−1.
  - Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Package `sphere_fetch_pkg`:
  - PAIR_WORDS = 8.
  - Word-slot constants P1X..R2 (0..7).
  - State enum (IDLE, RUN, DRAIN, DONE).
- Sub-module `pair_fifo`: synchronous FIFO of width 8·DATA_WIDTH + ADDR_WIDTH. It provides push, pop, empty, full and an occupancy count. Reset is the same asynchronous active-high `rst`.

## Test plan
- `base_addr`=0, `num_pairs`=3, `pair_ready`=1 → reads at addresses 0, 8, 16 in consecutive cycles; first `pair_valid` at cycle 3; pairs 0..2 on consecutive cycles; `done` at cycle 6.
- `num_pairs`=0 → no `mem_oe`; `done` one cycle after `start`.
- `num_pairs`=10, `pair_ready` held low for 20 cycles → exactly 4 reads issued, then issue stops; no overflow; data and index held stable. On releasing ready, records 0..9 arrive in order and intact.
- `base_addr`=0xFFFFFFF8, `num_pairs`=2 → second read address is 0x00000000.
- `rst` pulsed at cycle 4 of a 6-pair run → all outputs 0 next cycle, FIFO empty, no `done`. A new `start` then runs cleanly from pair 0.
- With `SPHERE_FETCH_STALL_CNT_EN`: ready low for 5 cycles while valid is high → `stall_cycles`=5.
